// File: rtl/fifo_stream_reader.sv
// Read-side master for the fifo block: pops words with 1-cycle read latency and re-presents them
// as a valid/ready stream, hiding the latency behind a 3-entry prefetch buffer.
module fifo_stream_reader #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        level
);

  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              inflight;
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [DWIDTH-1:0] buf_mem [3];
  logic              pop;
  logic [2:0]        committed;

  // Pointers cycle through the three buffer slots only.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already owed to words: buffered plus the one the fifo is returning now.
  // The pop decision never looks at m_ready, keeping the sink off the fifo's read path.
  assign committed  = {1'b0, count} + {2'b00, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (committed < 3'd3);

  assign m_valid    = (count != 2'd0);
  assign pop        = m_valid && m_ready;
  assign level      = count;
  assign count_next = count + {1'b0, inflight} - {1'b0, pop};

  always_comb begin
    m_data = buf_mem[0];
    case (rptr)
      2'd1:    m_data = buf_mem[1];
      2'd2:    m_data = buf_mem[2];
      default: m_data = buf_mem[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      wptr     <= 2'd0;
      rptr     <= 2'd0;
    end else begin
      count    <= count_next;
      inflight <= fifo_rd_en;
      if (inflight) wptr <= ptr_inc(wptr);
      if (pop)      rptr <= ptr_inc(rptr);
    end
  end

  // Buffer storage carries no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (!rst && inflight) begin
      case (wptr)
        2'd1:    buf_mem[1] <= fifo_data;
        2'd2:    buf_mem[2] <= fifo_data;
        default: buf_mem[0] <= fifo_data;
      endcase
    end
  end

  a_no_overcommit: assert property (@(posedge clk) disable iff (rst) committed <= 3'd3);
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
